// File: rtl/register_file_mp.sv
// Multi-read-port register file with same-cycle write bypass and a per-register
// pending scoreboard used by the issue stage to track in-flight operands.
module register_file_mp #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int NUM_READ_PORTS = 2,
    parameter int ZERO_REG       = 1,
    parameter int BYPASS         = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 write,
    input  logic [ADDR_WIDTH-1:0]                write_addr,
    input  logic [DATA_WIDTH-1:0]                write_data,
    input  logic                                 reserve,
    input  logic [ADDR_WIDTH-1:0]                reserve_addr,
    input  logic [NUM_READ_PORTS-1:0]            read_en,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ_PORTS-1:0]            read_busy,
    output logic [NUM_REGS-1:0]                  pending
);

    logic [DATA_WIDTH-1:0]                            regs [NUM_REGS];
    logic [NUM_REGS-1:0]                              pending_q;
    logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]        raddr;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]        rd_q;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]        rd_d;
    logic [NUM_READ_PORTS-1:0]                        busy_q;
    logic [NUM_READ_PORTS-1:0]                        busy_d;
    logic                                             write_eff;
    logic                                             reserve_eff;

    // An address is architecturally live if it exists and is not the hardwired zero.
    function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign raddr       = read_addr;
    assign write_eff   = write && addr_live(write_addr);
    assign reserve_eff = reserve && addr_live(reserve_addr);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rd_d   = '0;
        busy_d = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (addr_live(raddr[p])) begin
                if ((BYPASS != 0) && write_eff && (write_addr == raddr[p])) begin
                    rd_d[p] = write_data;
                end else begin
                    rd_d[p]   = regs[raddr[p]];
                    busy_d[p] = pending_q[raddr[p]];
                end
            end
        end
    end

    // NOTE: the register array is reset because reads after reset must return 0; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every read in this block sees pre-edge state.
            if (write_eff) begin
                regs[write_addr]      <= write_data;
                pending_q[write_addr] <= 1'b0;
            end
            // Placed after the write so a same-cycle reserve leaves the register pending.
            if (reserve_eff) begin
                pending_q[reserve_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q   <= '0;
            busy_q <= '0;
        end else begin
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                if (read_en[p]) begin
                    rd_q[p]   <= rd_d[p];
                    busy_q[p] <= busy_d[p];
                end
            end
        end
    end

    assign read_data = rd_q;
    assign read_busy = busy_q;
    assign pending   = pending_q;

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-read-port register file for the core's decode/operand-fetch stage.
- Supports N read ports, one write port and an optional hardwired-zero r0.
- Adds same-cycle write-to-read bypass; reads are never stalled by writes.
- Keeps a per-register pending (scoreboard) bit that the issue stage sets on reserve and the write port clears, so consumers can detect in-flight operands.

Parameters:
ADDR_WIDTH, 4, register address width
DATA_WIDTH, 32, register data width
NUM_REGS, 16, number of registers (≤ 2**ADDR_WIDTH; need not be a power of 2)
NUM_READ_PORTS, 2, number of independent read ports (≥1)
ZERO_REG, 1, 1 = r0 reads 0, ignores writes and is never pending
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
write  input  1  perform a write this cycle
write_addr  input  ADDR_WIDTH  write address
write_data  input  DATA_WIDTH  write data
reserve  input  1  mark reserve_addr pending this cycle
reserve_addr  input  ADDR_WIDTH  register to mark pending
read_en  input  NUM_READ_PORTS  per-port read enable
read_addr  input  NUM_READ_PORTS*ADDR_WIDTH  packed; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
read_data  output  NUM_READ_PORTS*DATA_WIDTH  packed; port p at [p*DATA_WIDTH +: DATA_WIDTH]
read_busy  output  NUM_READ_PORTS  1 = returned operand was pending
pending  output  NUM_REGS  live scoreboard vector, bit i = register i pending

Behaviour:
- Reset (reset=0, asynchronous, no clock needed): all registers, read_data, read_busy and pending go to 0. State holds at 0 while reset is low. Operations resume on the first rising edge after reset goes high.
- A write is "effective" when all hold: write=1; write_addr < NUM_REGS; not (ZERO_REG=1 and write_addr=0).
  - Effective write: registers[write_addr] <= write_data and pending[write_addr] <= 0 at the edge.
  - Ineffective write: silently ignored.
- A reserve is "effective" under the same address rules: pending[reserve_addr] <= 1 at the edge.
  - Effective reserve with an effective write to the same address in the same cycle: data is written AND pending ends at 1 (reserve wins).
- Read port p, 1-cycle latency:
  - read_en[p]=1: read_data[p] and read_busy[p] update at the edge.
  - read_en[p]=0: both hold their previous values.
  - read_data value, first matching rule:
    1. ZERO_REG=1 and addr=0 -> 0.
    2. addr ≥ NUM_REGS -> 0.
    3. BYPASS=1 and effective write to addr this cycle -> write_data.
    4. Otherwise registers[addr] before the edge.
  - read_busy value:
    - 0 for rules 1, 2 and 3.
    - pending[addr] before the edge for rule 4.
    - A same-cycle reserve is not visible to a read until the next cycle.
  - BYPASS=0 with a same-cycle write to the read address: returns old data and old pending bit.
- Writes never block reads; all ports operate every cycle independently, including several ports reading the same address.
- pending output is the registered scoreboard state, no combinational path from inputs.
- Reset asserted mid-operation discards all register contents and in-flight reads immediately.

Test Plan:
- Reset with reset=0 between edges -> read_data=0, read_busy=0, pending=0 immediately. Write r3=0xDEADBEEF, release reset, read r3 -> 0.
- Write r5=0x12345678; next cycle read r5 on ports 0 and 1 -> both read_data=0x12345678 one cycle later, read_busy=0.
- Same cycle: write r7=0xA5A5A5A5 and read r7 on port 0.
  - BYPASS=1 -> read_data=0xA5A5A5A5, read_busy=0.
  - BYPASS=0 -> previous r7 value.
- Write r0=0xFFFFFFFF with ZERO_REG=1, then read r0 -> 0, pending[0] stays 0. Reserve r0 -> ignored.
- Reserve r9; next cycle read r9 -> read_busy=1. Write r9=0x55 and reserve r9 in the same cycle -> pending[9]=1, data=0x55. Write r9=0x66 alone -> pending[9]=0, next read gives 0x66 with read_busy=0.
- NUM_REGS=12: write r13 ignored; read r13 -> 0. read_en=0 on port 1 while r5 changes -> port 1 output holds its previous value.
